mmi_initiator: RTL
==================

// Module: mmi_initiator
// PURPOSE
//  Bus-master end of the MMI register bus (valid/ready, wstrb, wdata/rdata, word addr).
//  Turns core load/store requests (RISC-V funct3 sizes) into single MMI transactions.
//  Sits between the core LSU and the MMI responder that holds the COP/CP registers.
//  Generates lanes and strobes, extends read data, and flags decode, alignment and timeout errors.
// PARAMETERS
//  ADDR_W     3            MMI word-address width (responder register index)
//  BASE_ADDR  32'h1000_0000  byte base of MMI window; bits [31:ADDR_W+2] are compared
//  TIMEOUT    16           max cycles mmi_valid is held without mmi_ready; must be >=2
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  req_valid   in   1       core request valid
//  req_ready   out  1       block can accept a request
//  req_we      in   1       1=store, 0=load
//  req_funct3  in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-aligned
//  rsp_valid   out  1       one-cycle response pulse
//  rsp_rdata   out  32      extended load data; 0 for stores and errors
//  rsp_err     out  1       qualified by rsp_valid
//  rsp_cause   out  2       0 ok, 1 decode miss, 2 misaligned/illegal funct3, 3 timeout
//  mmi_valid   out  1       bus request
//  mmi_ready   in   1       responder done; rdata is valid in that same cycle
//  mmi_wstrb   out  4       byte strobes; 0000 = read
//  mmi_wdata   out  32      lane-replicated store data
//  mmi_addr    out  ADDR_W  req_addr[ADDR_W+1:2]
//  mmi_rdata   in   32      responder read data
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; FSM returns to IDLE. Counter and captured
//   request are cleared. Reset asserted mid-transaction drops mmi_valid asynchronously.
//  FSM IDLE -> BUS | RESP;  BUS -> RESP;  RESP -> IDLE.
//  IDLE: req_ready=1. Accept on req_valid&req_ready and register all req_* fields.
//   Decode miss (addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) -> RESP, cause 1, no bus cycle.
//   H with addr[0]!=0, W with addr[1:0]!=0, load funct3 in {011,110,111}, or store
//    funct3 >010 -> RESP, cause 2, no bus cycle. Decode miss wins over alignment.
//   Otherwise -> BUS.
//  BUS: mmi_valid=1, req_ready=0. addr, wstrb and wdata are held stable until the handshake.
//   Handshake = mmi_valid & mmi_ready. Capture extended rdata, go to RESP.
//   Wait counter is 0 on entry and increments each cycle without ready.
//   At count TIMEOUT-1 with no ready: drop valid next cycle -> RESP, cause 3.
//   Ready arriving in the timeout cycle counts as success, not timeout.
//  RESP: rsp_valid=1 for exactly one cycle -> IDLE. No backpressure on rsp.
//  Latency: accept at cycle 0; mmi_valid rises at cycle 1; ready at cycle k>=1;
//   rsp_valid at k+1. An error with no bus cycle gives rsp_valid at cycle 1.
//  Store strobes/data: SB wstrb=0001<<a[1:0], wdata={4{b}}; SH wstrb=0011<<{a[1],1'b0},
//   wdata={2{h}}; SW wstrb=1111, wdata=req_wdata.
//  Load: wstrb=0000, wdata=0. rdata lane = a[1:0] for bytes, a[1] for halfwords.
//   B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
//  mmi_* outputs are 0 whenever mmi_valid=0. At most one outstanding transaction.
//  mmi_rdata is ignored unless the handshake occurs.
// STRUCTURE
//  mmi_pkg: FSM state encodings, funct3 constants, rsp_cause codes.
//  Sub-module mmi_lane_align (combinational): wstrb/wdata generation, load extension,
//   and alignment-check output. Top holds the FSM, request registers and wait counter.
// TESTING
//  SW 0x1000_0008 data 0xDEADBEEF, ready after 2 cycles -> addr=2, wstrb=1111,
//   wdata=0xDEADBEEF; rsp_valid at cycle 4 with err=0.
//  SB 0x1000_0003 data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
//  LB 0x1000_0001 with rdata=0x0000_8000 -> rsp_rdata=0xFFFF_FF80.
//   LBU at the same address -> rsp_rdata=0x0000_0080.
//  LH 0x1000_0002 with rdata=0x8001_0000 -> rsp_rdata=0xFFFF_8001.
//   LW 0x1000_0002 -> cause 2, mmi_valid never rises.
//  Load from 0x2000_0000 -> cause 1 at cycle 1, no bus cycle. With ready tied 0 ->
//   mmi_valid high for 16 cycles, then cause 3. Ready on the 16th cycle -> ok.
//  Reset deasserted to asserted (rst=0) while in BUS -> mmi_valid=0 immediately, req_ready=1
//   after release, and the next request completes normally.

Source files
------------

// File: rtl/mmi_pkg.sv
// Shared definitions for the MMI bus-master block.
// Contents:
//   state_t         - initiator FSM state encodings
//   F3_*            - RISC-V load/store funct3 size codes
//   CAUSE_*         - rsp_cause codes reported to the core
package mmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_OK      = 2'd0;
    localparam logic [1:0] CAUSE_DECODE  = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/mmi_lane_align.sv
// Combinational lane logic for the MMI initiator.
// Ports:
//   we, funct3, addr_lo   - access type, size and byte offset within the word
//   wdata_in              - right-aligned store data from the core
//   rdata_in              - raw word returned by the responder
//   wstrb, wdata          - bus strobes and lane-replicated store data (0 for loads)
//   rdata_ext             - selected and sign/zero-extended load data
//   bad                   - misaligned access or funct3 not legal for this direction
module mmi_lane_align
    import mmi_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic        bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    always_comb begin
        byte_sel  = rdata_in[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata_in[15:8];
            2'd2:    byte_sel = rdata_in[23:16];
            2'd3:    byte_sel = rdata_in[31:24];
            default: byte_sel = rdata_in[7:0];
        endcase
        half_sel  = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];

        st_strb   = 4'b0000;
        st_data   = 32'h0;
        rdata_ext = 32'h0;
        bad       = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                st_strb   = 4'b0001 << addr_lo;
                st_data   = {4{wdata_in[7:0]}};
                rdata_ext = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h0, byte_sel};
                // unsigned sizes exist only for loads
                bad       = we && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                st_strb   = 4'b0011 << {addr_lo[1], 1'b0};
                st_data   = {2{wdata_in[15:0]}};
                rdata_ext = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0, half_sel};
                bad       = addr_lo[0] || (we && (funct3 == F3_HU));
            end
            F3_W: begin
                st_strb   = 4'b1111;
                st_data   = wdata_in;
                rdata_ext = rdata_in;
                bad       = |addr_lo;
            end
            default: bad = 1'b1;
        endcase

        wstrb = we ? st_strb : 4'b0000;
        wdata = we ? st_data : 32'h0;
    end

endmodule

// File: rtl/mmi_initiator.sv
// Bus-master end of the MMI register bus. Converts one core load/store
// request at a time into a single valid/ready MMI transaction and returns a
// one-cycle response carrying extended load data or an error cause.
// Ports:
//   clk, rst                 - clock; asynchronous active-low reset
//   req_*                    - core request (valid/ready, we, funct3, addr, wdata)
//   rsp_valid/rdata/err/cause- one-cycle response pulse to the core
//   mmi_valid/ready          - bus handshake
//   mmi_wstrb/wdata/addr     - bus request fields (all 0 while mmi_valid=0)
//   mmi_rdata                - responder read data, used only on handshake
module mmi_initiator
    import mmi_pkg::*;
#(
    parameter int          ADDR_W    = 3,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        rsp_cause,
    output logic              mmi_valid,
    input  logic              mmi_ready,
    output logic [3:0]        mmi_wstrb,
    output logic [31:0]       mmi_wdata,
    output logic [ADDR_W-1:0] mmi_addr,
    input  logic [31:0]       mmi_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t           state_reg;
    logic             we_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       addr_lo_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             sel_we;
    logic [2:0]       sel_funct3;
    logic [1:0]       sel_addr_lo;
    logic [3:0]       al_wstrb;
    logic [31:0]      al_wdata;
    logic [31:0]      al_rdata;
    logic             al_bad;
    logic             decode_miss;
    logic             accept;

    // The lane logic looks at the live request while idle (to build strobes
    // at accept time) and at the captured request afterwards (to extend read
    // data at the handshake), so one instance serves both.
    assign sel_we      = (state_reg == ST_IDLE) ? req_we        : we_reg;
    assign sel_funct3  = (state_reg == ST_IDLE) ? req_funct3    : funct3_reg;
    assign sel_addr_lo = (state_reg == ST_IDLE) ? req_addr[1:0] : addr_lo_reg;

    mmi_lane_align u_lane_align (
        .we        (sel_we),
        .funct3    (sel_funct3),
        .addr_lo   (sel_addr_lo),
        .wdata_in  (req_wdata),
        .rdata_in  (mmi_rdata),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .rdata_ext (al_rdata),
        .bad       (al_bad)
    );

    assign decode_miss = (req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    assign accept      = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            we_reg      <= 1'b0;
            funct3_reg  <= 3'b000;
            addr_lo_reg <= 2'b00;
            cnt_reg     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_cause   <= CAUSE_OK;
            mmi_valid   <= 1'b0;
            mmi_wstrb   <= 4'b0000;
            mmi_wdata   <= 32'h0;
            mmi_addr    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg      <= req_we;
                        funct3_reg  <= req_funct3;
                        addr_lo_reg <= req_addr[1:0];
                        cnt_reg     <= '0;
                        req_ready   <= 1'b0;
                        if (decode_miss) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_cause <= CAUSE_DECODE;
                        end else if (al_bad) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_cause <= CAUSE_ALIGN;
                        end else begin
                            state_reg <= ST_BUS;
                            mmi_valid <= 1'b1;
                            mmi_addr  <= req_addr[ADDR_W+1:2];
                            mmi_wstrb <= al_wstrb;
                            mmi_wdata <= al_wdata;
                        end
                    end
                end
                ST_BUS: begin
                    // ready in the final wait cycle still wins over timeout
                    if (mmi_ready) begin
                        state_reg <= ST_RESP;
                        mmi_valid <= 1'b0;
                        mmi_wstrb <= 4'b0000;
                        mmi_wdata <= 32'h0;
                        mmi_addr  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_reg ? 32'h0 : al_rdata;
                        rsp_err   <= 1'b0;
                        rsp_cause <= CAUSE_OK;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg <= ST_RESP;
                        mmi_valid <= 1'b0;
                        mmi_wstrb <= 4'b0000;
                        mmi_wdata <= 32'h0;
                        mmi_addr  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_cause <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                    rsp_cause <= CAUSE_OK;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
